// File: rtl/fusion_out_stream.sv
// Output stage after the fusion pipeline: valid tracking, FWFT buffer, AXI4-Stream master.
// Define FUSION_OUT_ROW_TLAST_EN to put tlast at every row end instead of only at frame end.
module fusion_out_stream #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int INPUT_WIDTH     = 8,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = INPUT_WIDTH * PIXELS_PER_BEAT,
    parameter int PIPE_LATENCY    = 13,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] fused_frame,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  frame_done,
    output logic [15:0]           frame_count
);

    localparam int BEATS_PER_FRAME = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int CNT_W           = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam int AW              = $clog2(FIFO_DEPTH);
`ifdef FUSION_OUT_ROW_TLAST_EN
    // Rows narrower than one beat still end on every beat.
    localparam int ROW_BEATS = (IMAGE_DIM >= PIXELS_PER_BEAT) ? IMAGE_DIM / PIXELS_PER_BEAT : 1;
    localparam int ENTRY_W   = DATA_WIDTH + 3;
`else
    localparam int ENTRY_W   = DATA_WIDTH + 2;
`endif

    logic [PIPE_LATENCY-1:0] vld_sr_q, vld_sr_d, vld_shift;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    frame_done_q, frame_done_d;
    logic [15:0]             frame_count_q, frame_count_d;

    logic                    push, pop;
    logic                    tuser_tag, tlast_tag, frame_end_tag;
    logic [ENTRY_W-1:0]      wr_entry, head;
    logic                    head_frame_end;
    logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LATENCY; gi++) begin : g_vld
            if (gi == 0) begin : g_first
                assign vld_shift[gi] = in_valid;
            end else begin : g_rest
                assign vld_shift[gi] = vld_sr_q[gi-1];
            end
        end
    endgenerate

    // Stall depends only on registered occupancy, so tready never reaches it combinationally.
    assign stall         = (count_q == (AW+1)'(FIFO_DEPTH));
    assign push          = ~stall & vld_sr_q[PIPE_LATENCY-1];
    assign m_axis_tvalid = (count_q != '0);
    assign pop           = m_axis_tvalid & m_axis_tready;

    assign frame_end_tag = (beat_cnt_q == CNT_W'(BEATS_PER_FRAME - 1));
    assign tuser_tag     = (beat_cnt_q == '0);

`ifdef FUSION_OUT_ROW_TLAST_EN
    assign tlast_tag      = ((int'(beat_cnt_q) % ROW_BEATS) == ROW_BEATS - 1);
    assign wr_entry       = {frame_end_tag, tuser_tag, tlast_tag, fused_frame};
    assign head_frame_end = head[DATA_WIDTH+2];
`else
    assign tlast_tag      = frame_end_tag;
    assign wr_entry       = {tuser_tag, tlast_tag, fused_frame};
    assign head_frame_end = head[DATA_WIDTH];
`endif

    // First-word-fall-through: the head entry is read without a register stage.
    assign head          = mem_q[rd_ptr_q];
    assign m_axis_tdata  = head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = m_axis_tvalid & head[DATA_WIDTH];
    assign m_axis_tuser  = m_axis_tvalid & head[DATA_WIDTH+1];
    assign frame_done    = frame_done_q;
    assign frame_count   = frame_count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_comb begin
        vld_sr_d      = stall ? vld_sr_q : vld_shift;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        beat_cnt_d    = beat_cnt_q;
        frame_done_d  = pop & head_frame_end;
        frame_count_d = frame_count_q;

        if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            beat_cnt_d = frame_end_tag ? '0 : beat_cnt_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (pop & head_frame_end) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_sr_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            beat_cnt_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            vld_sr_q      <= vld_sr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            beat_cnt_q    <= beat_cnt_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_fusion_out_stream.sv
// Bench for fusion_out_stream: 8x8 frames of 16-pixel beats (4 beats/frame), latency 3, depth 4.
module tb_fusion_out_stream;

    localparam int PPB   = 16;
    localparam int IW    = 8;
    localparam int DIM   = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int DW    = PPB * IW;
    localparam int BPF   = DIM * DIM / PPB;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] fused_frame;
    logic          stall;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b1;
    logic          tlast;
    logic          tuser;
    logic          frame_done;
    logic [15:0]   frame_count;

    logic [7:0]    in_byte = 8'hEE;
    logic          stall_s = 1'b0;
    logic [DW-1:0] fus_pipe [LAT];

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;
    beat_t obs_q[$];

    typedef struct {
        logic        iv;
        logic [7:0]  b;
        logic        rdy;
        logic        e_stall;
        logic        e_tv;
        logic [7:0]  e_b;
        logic        e_u;
        logic        e_l;
        logic        e_fd;
        logic [15:0] e_fc;
    } vec_t;
    vec_t vecs[13];

    fusion_out_stream #(
        .PIXELS_PER_BEAT(PPB),
        .INPUT_WIDTH    (IW),
        .IMAGE_DIM      (DIM),
        .PIPE_LATENCY   (LAT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .in_valid     (in_valid),
        .fused_frame  (fused_frame),
        .stall        (stall),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast (tlast),
        .m_axis_tuser (tuser),
        .frame_done   (frame_done),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    // Upstream fusion stand-in: a data delay line frozen by stall.
    always @(posedge clk) begin
        if (!aresetn) begin
            for (int i = 0; i < LAT; i++) fus_pipe[i] <= '0;
        end else if (!stall_s) begin
            fus_pipe[0] <= {PPB{in_byte}};
            for (int i = 1; i < LAT; i++) fus_pipe[i] <= fus_pipe[i-1];
        end
    end
    assign fused_frame = fus_pipe[LAT-1];

    // Downstream sink monitor, sampled mid-cycle.
    always @(negedge clk) begin
        stall_s <= stall;
        if (aresetn && tvalid && tready) obs_q.push_back({tdata, tuser, tlast});
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic vec_t mk(input logic iv, input logic [7:0] b, input logic rdy,
                                input logic est, input logic etv, input logic [7:0] eb,
                                input logic eu, input logic el, input logic efd,
                                input logic [15:0] efc);
        vec_t v;
        v.iv = iv; v.b = b; v.rdy = rdy; v.e_stall = est; v.e_tv = etv;
        v.e_b = eb; v.e_u = eu; v.e_l = el; v.e_fd = efd; v.e_fc = efc;
        return v;
    endfunction

    function automatic logic exp_last(input int pos);
`ifdef FUSION_OUT_ROW_TLAST_EN
        return 1'b1;
`else
        return (pos % BPF) == BPF - 1;
`endif
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout required event", nm);
    endtask

    // Presents n beats, holding each until a cycle without stall accepts it.
    task automatic drive(input logic [7:0] first, input int n, input int gap, input int budget);
        int  cyc = 0;
        bit  acc;
        for (int k = 0; k < n; k++) begin
            acc      = 1'b0;
            in_valid = 1'b1;
            in_byte  = first + 8'(k);
            while (!acc && cyc < budget) begin
                @(negedge clk);
                acc = !stall;
                @(posedge clk); #1;
                cyc++;
            end
            in_valid = 1'b0;
            in_byte  = 8'hEE;
            if (!acc) begin
                timeout("drive_accept");
                return;
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_obs(input int n, input int budget, input string nm);
        int w = 0;
        while (obs_q.size() < n && w < budget) begin
            @(posedge clk); #1;
            w++;
        end
        if (obs_q.size() < n) timeout(nm);
    endtask

    task automatic check_beats(input string nm, input logic [7:0] first, input int n);
        beat_t      bt;
        logic [7:0] b;
        chk({nm, "_count"}, DW'(obs_q.size()), DW'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            bt = obs_q[i];
            b  = first + 8'(i);
            $display("%s beat %0d data=%h tuser=%b tlast=%b", nm, i, bt.d[7:0], bt.u, bt.l);
            chk($sformatf("%s_data%0d", nm, i), bt.d, {PPB{b}});
            chk($sformatf("%s_tuser%0d", nm, i), DW'(bt.u), DW'((i % BPF) == 0));
            chk($sformatf("%s_tlast%0d", nm, i), DW'(bt.l), DW'(exp_last(i)));
        end
    endtask

    initial begin
        int   fd_base;
        int   w;
        vec_t v;
        logic el;

        vecs[0]  = mk(0, 8'hEE, 1, 0, 0, 8'h00, 0, 0, 0, 16'd0);
        vecs[1]  = mk(0, 8'hEE, 1, 0, 0, 8'h00, 0, 0, 0, 16'd0);
        vecs[2]  = mk(0, 8'hEE, 1, 0, 0, 8'h00, 0, 0, 0, 16'd0);
        vecs[3]  = mk(1, 8'h11, 1, 0, 0, 8'h00, 0, 0, 0, 16'd0);
        vecs[4]  = mk(1, 8'h22, 1, 0, 0, 8'h00, 0, 0, 0, 16'd0);
        vecs[5]  = mk(1, 8'h33, 1, 0, 0, 8'h00, 0, 0, 0, 16'd0);
        vecs[6]  = mk(1, 8'h44, 1, 0, 0, 8'h00, 0, 0, 0, 16'd0);
        vecs[7]  = mk(0, 8'hEE, 1, 0, 1, 8'h11, 1, 0, 0, 16'd0);
        vecs[8]  = mk(0, 8'hEE, 1, 0, 1, 8'h22, 0, 0, 0, 16'd0);
        vecs[9]  = mk(0, 8'hEE, 1, 0, 1, 8'h33, 0, 0, 0, 16'd0);
        vecs[10] = mk(0, 8'hEE, 1, 0, 1, 8'h44, 0, 1, 0, 16'd0);
        vecs[11] = mk(0, 8'hEE, 1, 0, 0, 8'h00, 0, 0, 1, 16'd1);
        vecs[12] = mk(0, 8'hEE, 1, 0, 0, 8'h00, 0, 0, 0, 16'd1);

        // Reset state while aresetn is held low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", DW'(tvalid), '0);
        chk("rst_stall", DW'(stall), '0);
        chk("rst_tlast", DW'(tlast), '0);
        chk("rst_tuser", DW'(tuser), '0);
        chk("rst_frame_done", DW'(frame_done), '0);
        chk("rst_frame_count", DW'(frame_count), '0);
        aresetn = 1'b1;

        // Idle, then one frame of 4 beats with tready high, cycle by cycle.
        for (int r = 0; r < 13; r++) begin
            v        = vecs[r];
            in_valid = v.iv;
            in_byte  = v.b;
            tready   = v.rdy;
            @(negedge clk);
`ifdef FUSION_OUT_ROW_TLAST_EN
            el = v.e_tv;
`else
            el = v.e_l;
`endif
            $display("vec %0d iv=%b tv=%b data=%h tuser=%b tlast=%b fd=%b fc=%0d",
                     r, v.iv, tvalid, tdata[7:0], tuser, tlast, frame_done, frame_count);
            chk($sformatf("vec%0d_stall", r), DW'(stall), DW'(v.e_stall));
            chk($sformatf("vec%0d_tvalid", r), DW'(tvalid), DW'(v.e_tv));
            if (v.e_tv) chk($sformatf("vec%0d_tdata", r), tdata, {PPB{v.e_b}});
            chk($sformatf("vec%0d_tuser", r), DW'(tuser), DW'(v.e_u));
            chk($sformatf("vec%0d_tlast", r), DW'(tlast), DW'(el));
            chk($sformatf("vec%0d_frame_done", r), DW'(frame_done), DW'(v.e_fd));
            chk($sformatf("vec%0d_frame_count", r), DW'(frame_count), DW'(v.e_fc));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_byte  = 8'hEE;

        // Backpressure: fill until stall, hold, then drain.
        obs_q.delete();
        fd_base = fd_cnt;
        tready  = 1'b0;
        fork
            drive(8'h01, 8, 0, 300);
            begin
                w = 0;
                @(negedge clk);
                while (!stall && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                if (!stall) timeout("bp_stall_assert");
                for (int h = 0; h < 4; h++) begin
                    if (h > 0) @(negedge clk);
                    $display("bp hold %0d stall=%b tv=%b data=%h", h, stall, tvalid, tdata[7:0]);
                    chk($sformatf("bp_hold%0d_stall", h), DW'(stall), DW'(1));
                    chk($sformatf("bp_hold%0d_tvalid", h), DW'(tvalid), DW'(1));
                    chk($sformatf("bp_hold%0d_tdata", h), tdata, {PPB{8'h01}});
                    chk($sformatf("bp_hold%0d_tuser", h), DW'(tuser), DW'(1));
                end
                @(posedge clk); #1;
                tready = 1'b1;
            end
        join
        wait_obs(8, 80, "bp_drain");
        repeat (3) @(posedge clk);
        #1;
        check_beats("bp", 8'h01, 8);
        chk("bp_frame_count", DW'(frame_count), DW'(3));
        chk("bp_frame_done_pulses", DW'(fd_cnt - fd_base), DW'(2));

        // Alternating in_valid gaps; junk on the idle slots must be dropped.
        obs_q.delete();
        fd_base = fd_cnt;
        tready  = 1'b1;
        drive(8'hA1, 8, 1, 300);
        wait_obs(8, 60, "gap_drain");
        repeat (3) @(posedge clk);
        #1;
        check_beats("gap", 8'hA1, 8);
        chk("gap_frame_count", DW'(frame_count), DW'(5));
        chk("gap_frame_done_pulses", DW'(fd_cnt - fd_base), DW'(2));

        // Asynchronous reset mid-frame with two beats buffered.
        obs_q.delete();
        tready = 1'b0;
        drive(8'hB1, 2, 0, 50);
        repeat (LAT + 3) @(posedge clk);
        @(negedge clk);
        chk("mid_tvalid_before", DW'(tvalid), DW'(1));
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", DW'(tvalid), '0);
        chk("mid_rst_tuser", DW'(tuser), '0);
        chk("mid_rst_tlast", DW'(tlast), '0);
        chk("mid_rst_stall", DW'(stall), '0);
        chk("mid_rst_frame_count", DW'(frame_count), '0);
        @(posedge clk);
        @(posedge clk);
        #2;
        aresetn = 1'b1;
        tready  = 1'b1;
        @(posedge clk); #1;
        drive(8'hC1, 1, 0, 20);
        wait_obs(1, 20, "post_rst_beat");
        repeat (2) @(posedge clk);
        #1;
        check_beats("post_rst", 8'hC1, 1);
        chk("post_rst_frame_count", DW'(frame_count), '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fusion_out_stream.md
Name: fusion_out_stream

Overview:
- Output stage directly downstream of the fusion block.
- Tracks which fused beats are real by mirroring the fusion pipeline latency with a valid shift register.
- Buffers fused beats in a small first-word-fall-through FIFO and presents them as an AXI4-Stream master with frame markers.
- Drives the shared `stall` that freezes the upstream fusion pipeline when the buffer cannot accept another beat.

Parameters:
- PIXELS_PER_BEAT, 16, pixels per beat
- INPUT_WIDTH, 8, bits per pixel
- IMAGE_DIM, 512, square frame side in pixels
- DATA_WIDTH, INPUT_WIDTH*PIXELS_PER_BEAT, beat width
- PIPE_LATENCY, 13, fusion pipeline depth in advancing (non-stalled) cycles; must be ≥1
- FIFO_DEPTH, 16, output buffer entries; power of 2, ≥2

Ports:
- clk  in  1  clock
- aresetn  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  beat presented to fusion this cycle (qualified by ~stall)
- fused_frame  in  DATA_WIDTH  fusion output data
- stall  out  1  pipeline freeze to fusion and upstream
- m_axis_tdata  out  DATA_WIDTH  output beat
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of frame
- m_axis_tuser  out  1  first beat of frame
- frame_done  out  1  one-cycle pulse on last-beat handshake
- frame_count  out  16  completed frames, wraps at 65535→0

Behaviour:
- Reset (async, aresetn low) state:
  - Valid shift register cleared.
  - FIFO emptied; stall=0, m_axis_tvalid=0, tlast=0, tuser=0.
  - frame_done=0, frame_count=0, beat counter=0.
  - Reset mid-frame discards all in-flight and buffered beats; the first beat after reset is tagged tuser=1.
- Valid tracking:
  - vld_sr[PIPE_LATENCY-1:0] shifts in in_valid on each clock with stall=0; holds when stall=1.
  - vld_sr[PIPE_LATENCY-1] is aligned with fused_frame.
- Push:
  - push = ~stall & vld_sr[PIPE_LATENCY-1].
  - Writes {tuser_tag, tlast_tag, fused_frame} into the FIFO.
  - Beats with vld_sr=0 are dropped.
- Stall:
  - stall = (count == FIFO_DEPTH), driven from the registered count only; no combinational path from m_axis_tready.
  - A full FIFO popping in the same cycle still stalls that cycle; this one-beat bubble is accepted.
- Pop:
  - pop = m_axis_tvalid & m_axis_tready.
  - m_axis_tvalid = (count != 0). tdata/tlast/tuser are the head entry and stay stable while tvalid & ~tready.
- Simultaneous push & pop: count unchanged; both pointers advance.
- Push into empty: tvalid rises the next cycle. Latency from in_valid to tvalid = PIPE_LATENCY+1 cycles when never stalled.
- Beat counter:
  - Push-side, range 0..BEATS_PER_FRAME-1, where BEATS_PER_FRAME = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT.
  - tuser_tag = (cnt==0). tlast_tag = (cnt==BEATS_PER_FRAME-1). Wraps to 0 after the last beat.
- Frame completion: on pop with tlast=1, frame_done pulses high for one cycle (registered) and frame_count increments.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- No overflow path exists: push is impossible while stall=1. Pop while empty is impossible by construction.

Optional Feature:
- Macro FUSION_OUT_ROW_TLAST_EN.
- Defined: tlast_tag marks the end of every row, i.e. cnt mod (IMAGE_DIM/PIXELS_PER_BEAT) == IMAGE_DIM/PIXELS_PER_BEAT-1.
  - tuser stays frame-start only.
  - frame_done and frame_count still key on the true last beat of the frame, carried as an extra internal FIFO bit.
- Undefined: tlast on the last beat of the frame only; no extra FIFO bit.

Test Plan:
- Settings for all scenarios: IMAGE_DIM=8, PIXELS_PER_BEAT=16 (4 beats/frame), PIPE_LATENCY=3, FIFO_DEPTH=4.
- Reset then idle, tready=1 → stall=0, tvalid=0, frame_count=0 indefinitely.
- 4 consecutive in_valid beats, fused_frame=0x11..,0x22..,0x33..,0x44.. at the aligned cycles, tready=1:
  - tvalid first high 4 cycles after the first in_valid.
  - tuser on beat 0x11.., tlast on beat 0x44...
  - frame_done pulses once; frame_count=1.
- Continuous in_valid with tready=0:
  - stall asserts when count=4; vld_sr holds.
  - Then raise tready: all beats emerge in order, no loss or duplication, tdata stable while stalled.
- in_valid gaps (1,0,1,0,…) for 8 beats: only valid-aligned beats pushed; 2 frames counted; tlast on beats 4 and 8.
- aresetn pulsed low mid-frame with FIFO holding 2 beats:
  - tvalid drops immediately.
  - The next frame's first beat carries tuser=1.
  - frame_count=0.
- With FUSION_OUT_ROW_TLAST_EN, 4 beats: tlast on every beat (1 beat per row), frame_done only on the 4th.
